// File: rtl/sm3_pad_blk_buf.sv
// Ping-pong block assembler: packs the padded word stream into 512-bit blocks
// held in two banks and hands them downstream over a valid/ready handshake.
module sm3_pad_blk_buf #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pad_otpt_d_i,
    input  logic              pad_otpt_vld_i,
    input  logic              pad_otpt_lst_i,
    output logic              pad_otpt_ena_o,
    output logic [511:0]      blk_d_o,
    output logic              blk_vld_o,
    output logic              blk_lst_o,
    input  logic              blk_rdy_i,
    output logic              err_ovf_o,
    output logic              err_frm_o
);
    localparam int WPB = 512 / WORD_W;
    localparam int CW  = $clog2(WPB);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } bank_st_e;

    bank_st_e          st_q [2];
    bank_st_e          st_d [2];
    logic [1:0]        lst_q, lst_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_frm_q, err_frm_d;
    logic              rst_q;
    logic [511:0]      bank_flat [2];

    logic              word_acc;
    logic              blk_rel;
    logic              word_lastidx;
    logic              bank_close;

    // State register; rst_q lets ena be a pure register decode that stays low during reset.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            st_q[0]   <= ST_EMPTY;
            st_q[1]   <= ST_EMPTY;
            lst_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            wcnt_q    <= '0;
            err_ovf_q <= 1'b0;
            err_frm_q <= 1'b0;
        end else begin
            st_q[0]   <= st_d[0];
            st_q[1]   <= st_d[1];
            lst_q     <= lst_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wcnt_q    <= wcnt_d;
            err_ovf_q <= err_ovf_d;
            err_frm_q <= err_frm_d;
        end
    end

    // Next-state logic
    always_comb begin
        word_acc     = pad_otpt_vld_i & pad_otpt_ena_o;
        blk_rel      = blk_vld_o & blk_rdy_i;
        word_lastidx = (wcnt_q == CW'(WPB - 1));
        bank_close   = word_acc & (word_lastidx | pad_otpt_lst_i);

        st_d[0]   = st_q[0];
        st_d[1]   = st_q[1];
        lst_d     = lst_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wcnt_d    = wcnt_q;
        err_ovf_d = err_ovf_q | (pad_otpt_vld_i & ~pad_otpt_ena_o);
        err_frm_d = err_frm_q | (word_acc & pad_otpt_lst_i & ~word_lastidx);

        if (word_acc) begin
            if (bank_close) begin
                st_d[wr_ptr_q]  = ST_FULL;
                lst_d[wr_ptr_q] = pad_otpt_lst_i;
                wcnt_d          = '0;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                st_d[wr_ptr_q]  = ST_FILL;
                wcnt_d          = wcnt_q + CW'(1);
            end
        end
        // The write bank is never the FULL read bank, so these never collide.
        if (blk_rel) begin
            st_d[rd_ptr_q]  = ST_EMPTY;
            lst_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ~rd_ptr_q;
        end
    end

    // Output decode
    always_comb begin
        pad_otpt_ena_o = ~rst_q & (st_q[wr_ptr_q] != ST_FULL);
        blk_vld_o      = (st_q[rd_ptr_q] == ST_FULL);
        blk_lst_o      = lst_q[rd_ptr_q];
        blk_d_o        = bank_flat[rd_ptr_q];
        err_ovf_o      = err_ovf_q;
        err_frm_o      = err_frm_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [511:0] data_q;
            // Word 0 lands in the most significant slot; release zeroes the whole bank.
            always_ff @(posedge clk) begin
                if (rst || (blk_rel && (rd_ptr_q == 1'(gi)))) begin
                    data_q <= '0;
                end else if (word_acc && (wr_ptr_q == 1'(gi))) begin
                    data_q[(WPB - 1 - int'(wcnt_q)) * WORD_W +: WORD_W] <= pad_otpt_d_i;
                end
            end
            assign bank_flat[gi] = data_q;
        end
    endgenerate
endmodule

// File: tb/tb_sm3_pad_blk_buf.sv
// Directed bench for sm3_pad_blk_buf (WORD_W=32): reset, vectors, streaming,
// backpressure, overflow, framing error and mid-block reset.
module tb_sm3_pad_blk_buf;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pad_d;
    logic         pad_vld;
    logic         pad_lst;
    logic         pad_ena;
    logic [511:0] blk_d;
    logic         blk_vld;
    logic         blk_lst;
    logic         blk_rdy;
    logic         err_ovf;
    logic         err_frm;

    int n_checks = 0;
    int n_fail   = 0;

    sm3_pad_blk_buf #(.WORD_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pad_otpt_d_i   (pad_d),
        .pad_otpt_vld_i (pad_vld),
        .pad_otpt_lst_i (pad_lst),
        .pad_otpt_ena_o (pad_ena),
        .blk_d_o        (blk_d),
        .blk_vld_o      (blk_vld),
        .blk_lst_o      (blk_lst),
        .blk_rdy_i      (blk_rdy),
        .err_ovf_o      (err_ovf),
        .err_frm_o      (err_frm)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        pad_vld = 1'b1;
        pad_d   = d;
        pad_lst = l;
        step();
        pad_vld = 1'b0;
        pad_lst = 1'b0;
    endtask

    task automatic release_blk();
        blk_rdy = 1'b1;
        step();
        blk_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; pad_vld = 1'b0; pad_lst = 1'b0; pad_d = '0; blk_rdy = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [511:0] exp;
        rst = 1'b1; pad_vld = 1'b0; pad_lst = 1'b0; pad_d = '0; blk_rdy = 1'b0;
        step();
        n_checks++;
        if (pad_ena !== 1'b0) begin n_fail++; $display("FAIL rst_ena_low: got %b want 0", pad_ena); end
        n_checks++;
        if (blk_vld !== 1'b0 || blk_lst !== 1'b0 || blk_d !== '0) begin
            n_fail++; $display("FAIL rst_blk: vld=%b lst=%b d=%h want 0", blk_vld, blk_lst, blk_d);
        end
        n_checks++;
        if (err_ovf !== 1'b0 || err_frm !== 1'b0) begin
            n_fail++; $display("FAIL rst_err: ovf=%b frm=%b want 0 0", err_ovf, err_frm);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (pad_ena !== 1'b1) begin n_fail++; $display("FAIL rst_ena_high: got %b want 1", pad_ena); end
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            push(32'(i), i == 15);
            exp[511 - i*32 -: 32] = 32'(i);
            if (i == 14) begin
                n_checks++;
                if (blk_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld_early: got %b want 0", blk_vld); end
            end
        end
        n_checks++;
        if (blk_vld !== 1'b1) begin n_fail++; $display("FAIL rst_vld_latency: got %b want 1", blk_vld); end
        n_checks++;
        if (blk_d[511:480] !== 32'h0 || blk_d[31:0] !== 32'hF || blk_d !== exp) begin
            n_fail++; $display("FAIL rst_blk_data: got %h want %h", blk_d, exp);
        end
        n_checks++;
        if (blk_lst !== 1'b1) begin n_fail++; $display("FAIL rst_blk_lst: got %b want 1", blk_lst); end
        release_blk();
        n_checks++;
        if (blk_vld !== 1'b0 || blk_d !== '0) begin
            n_fail++; $display("FAIL rst_release: vld=%b d=%h want 0", blk_vld, blk_d);
        end
        $display("test_reset done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_abc();
        logic [511:0] exp;
        int           nblk;
        do_reset();
        exp = {32'h61626380, {14{32'h0}}, 32'h00000018};
        push(32'h61626380, 1'b0);
        for (int i = 0; i < 14; i++) push(32'h0, 1'b0);
        push(32'h00000018, 1'b1);
        n_checks++;
        if (blk_vld !== 1'b1 || blk_d !== exp || blk_lst !== 1'b1) begin
            n_fail++; $display("FAIL abc_block: vld=%b lst=%b d=%h want 1 1 %h", blk_vld, blk_lst, blk_d, exp);
        end
        release_blk();
        nblk = 0;
        for (int i = 0; i < 5; i++) begin
            if (blk_vld) nblk++;
            step();
        end
        n_checks++;
        if (nblk != 0) begin n_fail++; $display("FAIL abc_extra_block: saw %0d extra cycles of vld want 0", nblk); end
        $display("test_abc done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_streaming();
        logic [31:0] w0 [4];
        logic [31:0] w15 [4];
        logic        lsts [4];
        int          nblk;
        int          ena_drops;
        do_reset();
        blk_rdy = 1'b1;
        nblk = 0;
        ena_drops = 0;
        for (int i = 0; i < 51; i++) begin
            if (i < 48) begin
                if (pad_ena !== 1'b1) ena_drops++;
                push(32'(i), i == 47);
            end else begin
                step();
            end
            if (blk_vld === 1'b1) begin
                if (nblk < 4) begin
                    w0[nblk]   = blk_d[511:480];
                    w15[nblk]  = blk_d[31:0];
                    lsts[nblk] = blk_lst;
                end
                nblk++;
            end
        end
        blk_rdy = 1'b0;
        n_checks++;
        if (ena_drops != 0) begin n_fail++; $display("FAIL stream_ena: %0d drops want 0", ena_drops); end
        n_checks++;
        if (nblk != 3) begin
            n_fail++; $display("FAIL stream_count: got %0d blocks want 3", nblk);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (w0[k] !== 32'(16*k) || w15[k] !== 32'(16*k + 15) || lsts[k] !== (k == 2)) begin
                    n_fail++;
                    $display("FAIL stream_blk%0d: w0=%h w15=%h lst=%b want %h %h %b",
                             k, w0[k], w15[k], lsts[k], 32'(16*k), 32'(16*k + 15), k == 2);
                end
            end
        end
        $display("test_streaming done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_backpressure();
        int           acc;
        logic         ena_after32;
        logic [511:0] exp;
        do_reset();
        acc = 0;
        ena_after32 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pad_ena === 1'b1) acc++;
            push(32'(100 + i), 1'b0);
            if (i == 31) ena_after32 = pad_ena;
        end
        n_checks++;
        if (acc != 32) begin n_fail++; $display("FAIL bp_accepted: got %0d want 32", acc); end
        n_checks++;
        if (ena_after32 !== 1'b0) begin n_fail++; $display("FAIL bp_ena_fall: got %b want 0", ena_after32); end
        n_checks++;
        if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b want 1", err_ovf); end
        release_blk();
        n_checks++;
        if (pad_ena !== 1'b1 || blk_vld !== 1'b1 || blk_d[511:480] !== 32'd116) begin
            n_fail++; $display("FAIL bp_freed: ena=%b vld=%b w0=%0d want 1 1 116", pad_ena, blk_vld, blk_d[511:480]);
        end
        for (int i = 32; i < 40; i++) push(32'(100 + i), 1'b0);
        release_blk();
        n_checks++;
        if (blk_vld !== 1'b0) begin n_fail++; $display("FAIL bp_partial_vld: got %b want 0", blk_vld); end
        exp = '0;
        for (int j = 0; j < 8; j++) exp[511 - j*32 -: 32] = 32'(132 + j);
        for (int j = 0; j < 8; j++) begin
            exp[511 - (j+8)*32 -: 32] = 32'(200 + j);
            push(32'(200 + j), j == 7);
        end
        n_checks++;
        if (blk_vld !== 1'b1 || blk_d !== exp || blk_lst !== 1'b1) begin
            n_fail++; $display("FAIL bp_bank0: vld=%b lst=%b d=%h want 1 1 %h", blk_vld, blk_lst, blk_d, exp);
        end
        release_blk();
        $display("test_backpressure done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_overflow();
        logic [511:0] exp_a, exp_b;
        do_reset();
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < 32; i++) begin
            push(32'(300 + i), 1'b0);
            if (i < 16) exp_a[511 - i*32 -: 32] = 32'(300 + i);
            else        exp_b[511 - (i-16)*32 -: 32] = 32'(300 + i);
        end
        n_checks++;
        if (pad_ena !== 1'b0 || err_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_pre: ena=%b ovf=%b want 0 0", pad_ena, err_ovf);
        end
        pad_vld = 1'b1; pad_d = 32'hDEADBEEF; pad_lst = 1'b1;
        step(); step(); step();
        pad_vld = 1'b0; pad_lst = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
        n_checks++;
        if (blk_d !== exp_a || blk_lst !== 1'b0 || err_frm !== 1'b0) begin
            n_fail++; $display("FAIL ovf_blk_a: lst=%b frm=%b d=%h want 0 0 %h", blk_lst, err_frm, blk_d, exp_a);
        end
        release_blk();
        n_checks++;
        if (blk_vld !== 1'b1 || blk_d !== exp_b || err_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_blk_b: vld=%b ovf=%b d=%h want 1 1 %h", blk_vld, err_ovf, blk_d, exp_b);
        end
        release_blk();
        $display("test_overflow done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_framing();
        logic [511:0] exp;
        do_reset();
        blk_rdy = 1'b1;
        for (int i = 0; i < 32; i++) push(32'hFFFFFFFF, 1'b0);
        step(); step();
        blk_rdy = 1'b0;
        step();
        n_checks++;
        if (err_frm !== 1'b0 || blk_vld !== 1'b0) begin
            n_fail++; $display("FAIL frm_pre: frm=%b vld=%b want 0 0", err_frm, blk_vld);
        end
        exp = '0;
        for (int i = 0; i < 6; i++) begin
            exp[511 - i*32 -: 32] = 32'hA0 + 32'(i);
            push(32'hA0 + 32'(i), i == 5);
        end
        n_checks++;
        if (err_frm !== 1'b1) begin n_fail++; $display("FAIL frm_flag: got %b want 1", err_frm); end
        n_checks++;
        if (blk_vld !== 1'b1 || blk_lst !== 1'b1 || blk_d !== exp) begin
            n_fail++; $display("FAIL frm_block: vld=%b lst=%b d=%h want 1 1 %h", blk_vld, blk_lst, blk_d, exp);
        end
        release_blk();
        n_checks++;
        if (err_frm !== 1'b1) begin n_fail++; $display("FAIL frm_sticky: got %b want 1", err_frm); end
        $display("test_framing done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_mid_reset();
        logic [511:0] exp;
        int           vld_seen;
        do_reset();
        for (int i = 0; i < 7; i++) push(32'h77, 1'b0);
        rst = 1'b1;
        step();
        n_checks++;
        if (pad_ena !== 1'b0) begin n_fail++; $display("FAIL mrst_ena: got %b want 0", pad_ena); end
        rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (blk_vld !== 1'b0) vld_seen++;
        end
        n_checks++;
        if (vld_seen != 0 || pad_ena !== 1'b1) begin
            n_fail++; $display("FAIL mrst_no_vld: vld cycles=%0d ena=%b want 0 1", vld_seen, pad_ena);
        end
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[511 - i*32 -: 32] = 32'(500 + i);
            push(32'(500 + i), i == 15);
        end
        n_checks++;
        if (blk_vld !== 1'b1 || blk_lst !== 1'b1 || blk_d !== exp) begin
            n_fail++; $display("FAIL mrst_block: vld=%b lst=%b d=%h want 1 1 %h", blk_vld, blk_lst, blk_d, exp);
        end
        release_blk();
        $display("test_mid_reset done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_streaming();
        test_backpressure();
        test_overflow();
        test_framing();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sm3_pad_blk_buf.md
# sm3_pad_blk_buf

Block-assembly buffer at the output end of the SM3 padding stage. It consumes the padded word stream (`pad_otpt_*`) that the padding core emits under `pad_otpt_ena` flow control, and packs it into 512-bit message blocks. Two ping-pong banks hold the blocks, which are handed to the compression/expansion core over a valid/ready handshake. The block is the receiving end of the pad-output interface: it owns `pad_otpt_ena` and guarantees no padded word is lost while the downstream core is busy.

## Interface
- `WORD_W`, 32: width of a padded word; legal values 32 or 64. `WPB = 512/WORD_W` is the number of words per block (16 or 8).

- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `pad_otpt_d_i`  in  WORD_W  padded word; the first word of a block is the most significant
- `pad_otpt_vld_i`  in  1  word valid
- `pad_otpt_lst_i`  in  1  last word of the last block of a message
- `pad_otpt_ena_o`  out  1  permission for the padding core to present a word this cycle
- `blk_d_o`  out  512  assembled block; word 0 is at [511:512-WORD_W]
- `blk_vld_o`  out  1  block valid
- `blk_lst_o`  out  1  block is the final block of its message
- `blk_rdy_i`  in  1  downstream accepts the block
- `err_ovf_o`  out  1  sticky: a word arrived while `pad_otpt_ena_o` was low
- `err_frm_o`  out  1  sticky: `lst` arrived on a word index other than WPB-1

## Operation
- **Storage:** two banks of WPB words each, `bank[0..1]`. Each bank has:
  - a state: EMPTY, FILL or FULL
  - a stored `lst` flag
- **Pointers and counter:**
  - `wr_ptr` selects the bank being written; `rd_ptr` selects the bank being read.
  - `wcnt` (log2(WPB) bits) is the word index within the write bank.
- **Word accept:** a word is accepted when `pad_otpt_vld_i & pad_otpt_ena_o`.
  - The word is written to `bank[wr_ptr][wcnt]`, and the bank moves EMPTY→FILL.
  - If `wcnt==WPB-1` or `pad_otpt_lst_i`: the bank goes to FULL, its `lst` flag is stored, `wcnt` returns to 0 and `wr_ptr` toggles.
  - Otherwise `wcnt` increments.
- **Early `lst`:** `lst` with `wcnt!=WPB-1` sets `err_frm_o` and closes the bank early. The unwritten words stay zero.
- **`pad_otpt_ena_o`:** equals `state[wr_ptr]!=FULL`, decoded from registers only, with no combinational path from any input. It is forced to 0 while `rst` is high.
- **Dropped word:** `pad_otpt_vld_i` with `pad_otpt_ena_o` low drops the word, sets `err_ovf_o`, and leaves state unchanged.
- **Read side:**
  - `blk_vld_o = (state[rd_ptr]==FULL)`; `blk_d_o` and `blk_lst_o` come from `bank[rd_ptr]`.
  - On `blk_vld_o & blk_rdy_i`: the bank data is cleared to zero, the state goes to EMPTY and `rd_ptr` toggles.
- **Simultaneous events:** write-side and read-side updates to different banks in the same cycle are independent. The write bank can never be the FULL read bank, because writes are gated by `ena`.
- **Sticky errors:** the error flags are cleared only by `rst`.

## Timing
- **Reset values (all outputs, from the cycle after `rst` is sampled high):**
  - `pad_otpt_ena_o`=0 while `rst` is high, then 1 after release
  - `blk_vld_o`=0, `blk_lst_o`=0, `blk_d_o`=0
  - `err_ovf_o`=0, `err_frm_o`=0
  - Internally: both banks EMPTY and zeroed; `wr_ptr`=`rd_ptr`=0; `wcnt`=0.
- **Reset mid-operation:** all partially filled and FULL blocks are discarded; no partial block is ever presented.
- **Latency:** the final word of a block is accepted in cycle N; `blk_vld_o` rises in cycle N+1.
- **Freed bank:** a block released in cycle M makes its bank writable in cycle M+1; `ena` can rise in M+1.
- **Throughput:** with `blk_rdy_i` held high, a continuous word stream at one word per cycle is accepted with no `ena` deassertion.
- **Backpressure:** with `blk_rdy_i` low, at most 2·WPB words are accepted. `ena` falls in the cycle after the word that fills the second bank.
- **Downstream hold:** `blk_d_o` and `blk_lst_o` stay stable while `blk_vld_o & !blk_rdy_i`.

## Test plan
- **Reset state:** WORD_W=32; after `rst`, check `ena`=1, `blk_vld_o`=0 and both error flags 0 -> feed words 0x00000000..0x0000000F, with `lst` on the 16th -> `blk_vld_o` is high in the cycle after the 16th word, `blk_d_o[511:480]`=0x00000000, `blk_d_o[31:0]`=0x0000000F, `blk_lst_o`=1.
- **"abc" standard vector:** feed the padded words 0x61626380, then 0x00000000 ×14, then 0x00000018 (with `lst`) -> exactly one block is produced, equal to the concatenation of those words, with `blk_lst_o`=1.
- **Streaming:** 3 blocks (48 words) back-to-back with `blk_rdy_i`=1 -> `ena` never drops; 3 blocks are emitted in order; only the 3rd has `lst`=1.
- **Backpressure:** `blk_rdy_i`=0 with 40 words offered -> 32 are accepted and `ena` falls after word 32. Raise `rdy` for 1 cycle -> `ena`=1 in the next cycle, and words 33-40 land in bank 0.
- **Overflow:** drive `vld` while `ena`=0 -> `err_ovf_o`=1 stays sticky, and block contents are unchanged.
- **Framing error and mid-block reset:** `lst` on word index 5 -> `err_frm_o`=1, and the block has words 6-15 equal to 0 with `blk_lst_o`=1. Then a separate run: assert `rst` after 7 words -> `blk_vld_o` never rises, and the next 16 words form a correct block.
